irrigation_sequencer: RTL

Clocked sequencer that decides when and how the garden is watered. It owns the sprinkler pump (`bs`), drip valve (`vs`), tank inlet valve (`ve`) and alarm (`al`), and replaces the purely combinational irrigation and level logic with debounced inputs, minimum and maximum watering times, a cooldown lockout and a latched fault state. It sits between the raw sensor pins and the existing seven-segment display path, which consumes `state_code`.

---
 rtl/rega_pkg.sv | 24 ++
 rtl/sensor_debounce.sv | 38 +++
 rtl/irrigation_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rega_pkg.sv
// Shared types and default timing for the irrigation sequencer.
// Timing defaults assume a 50 MHz system clock.
package rega_pkg;

    localparam int STATE_CODE_W = 3;

    typedef enum logic [STATE_CODE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [31:0] DEF_MIN_ON_CYCLES   = 32'd3000000;
    localparam logic [31:0] DEF_MAX_ON_CYCLES   = 32'd30000000;
    localparam logic [31:0] DEF_COOLDOWN_CYCLES = 32'd6000000;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The output moves only after the synced input differs for DEBOUNCE_CYCLES edges.
module sensor_debounce
    import rega_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic        s1;
    logic        s2;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= 16'd0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= 16'd0;
            end else if (cnt >= DEBOUNCE_CYCLES - 16'd1) begin
                dout <= s2;
                cnt  <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Watering sequencer: filtered sensors, refill hysteresis, alarm,
// and the IDLE/SPRINKLE/DRIP/COOLDOWN/FAULT state machine.
module irrigation_sequencer
    import rega_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [31:0] MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
    parameter logic [31:0] MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
    parameter logic [31:0] COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    h,
    input  logic                    m,
    input  logic                    l,
    input  logic                    us,
    input  logic                    ua,
    input  logic                    t,
    output logic                    bs,
    output logic                    vs,
    output logic                    ve,
    output logic                    al,
    output logic [STATE_CODE_W-1:0] state_code,
    output logic                    err
);

    logic [5:0] raw;
    logic [5:0] filt;
    logic       fh, fm, fl, fus, fua, ft;
    logic       err_c;
    logic       crit;
    state_e     state;
    logic [31:0] cnt;

    assign raw = {h, m, l, us, ua, t};

    for (genvar i = 0; i < 6; i++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .din (raw[i]),
            .dout(filt[i])
        );
    end

    assign {fh, fm, fl, fus, fua, ft} = filt;

    assign err_c = (fh & ~fm) | (fm & ~fl);
    assign crit  = ~fl & ~err_c;
    assign err   = err_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ve <= 1'b0;
            al <= 1'b0;
        end else begin
            al <= err_c | crit;
            if (err_c)    ve <= 1'b0;
            else if (!fm) ve <= 1'b1;
            else if (fh)  ve <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 32'd0;
            bs         <= 1'b0;
            vs         <= 1'b0;
            state_code <= '0;
        end else begin
            bs         <= (state == ST_SPRINKLE);
            vs         <= (state == ST_DRIP);
            state_code <= state;
            unique case (state)
                ST_IDLE: begin
                    cnt <= 32'd0;
                    if (err_c) begin
                        state <= ST_FAULT;
                    end else if (fus && fm) begin
                        state <= (fua || ft) ? ST_DRIP : ST_SPRINKLE;
                    end
                end
                ST_SPRINKLE, ST_DRIP: begin
                    if (err_c) begin
                        state <= ST_FAULT;
                        cnt   <= 32'd0;
                    end else if (!fl
                              || cnt == MAX_ON_CYCLES - 32'd1
                              || (!fus && cnt >= MIN_ON_CYCLES - 32'd1)) begin
                        state <= ST_COOLDOWN;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_COOLDOWN: begin
                    if (err_c) begin
                        state <= ST_FAULT;
                        cnt   <= 32'd0;
                    end else if (cnt >= COOLDOWN_CYCLES - 32'd1) begin
                        state <= ST_IDLE;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_FAULT: begin
                    // counter tracks consecutive healthy cycles before release
                    if (err_c || !fl) begin
                        cnt <= 32'd0;
                    end else if (cnt >= {16'd0, DEBOUNCE_CYCLES} - 32'd1) begin
                        state <= ST_COOLDOWN;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 32'd0;
                end
            endcase
        end
    end

endmodule
